// File: rtl/instr_fetch_pkg.sv
// Shared defaults and the buffered fetch entry layout for the instruction fetch stage.
package instr_fetch_pkg;

   localparam int unsigned FETCH_ADDR_W   = 12;
   localparam int unsigned FETCH_DATA_W   = 16;
   localparam int unsigned FETCH_RESET_PC = 0;
   localparam int unsigned FETCH_DEPTH    = 4;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] instr;
   } fetch_entry_t;

   // Address of the word following pc, wrapping at the address width.
   function automatic logic [FETCH_ADDR_W-1:0] next_pc(input logic [FETCH_ADDR_W-1:0] pc);
      return pc + FETCH_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch stage bus: instruction memory read port, redirect/halt control and decoder handshake.
interface instr_fetch_if
   import instr_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = FETCH_ADDR_W,
   parameter int unsigned DATA_W = FETCH_DATA_W
);

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;

   modport master (
      output mem_addr,
      output mem_re,
      input  mem_rdata,
      input  redirect_valid,
      input  redirect_pc,
      input  halt,
      output instr_valid,
      output instr_data,
      output instr_pc,
      input  instr_ready
   );

   modport slave (
      input  mem_addr,
      input  mem_re,
      output mem_rdata,
      output redirect_valid,
      output redirect_pc,
      output halt,
      input  instr_valid,
      input  instr_data,
      input  instr_pc,
      output instr_ready
   );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries; synchronous flush wins over
// push and pop, and simultaneous push/pop is allowed at any occupancy.
module instr_fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 28
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   input  logic                       flush,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WIDTH-1:0]           head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO may still accept a push then.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop && !flush));

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, credit-limited memory read issue, response tagging
// and buffering, with branch redirect (flush) and halt.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = FETCH_ADDR_W,
   parameter int unsigned DATA_W   = FETCH_DATA_W,
   parameter int unsigned RESET_PC = FETCH_RESET_PC,
   parameter int unsigned DEPTH    = FETCH_DEPTH
) (
   input  logic           clk,
   input  logic           rst_n,
   instr_fetch_if.master  bus
);

   localparam int unsigned WIDTH = ADDR_W + DATA_W;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              inflight_q, inflight_d;

   logic [CNT_W-1:0]  count;
   logic [CNT_W:0]    credit_used;
   logic              full, empty;
   logic [WIDTH-1:0]  head;
   logic              issue, push, pop, flush;

   // Buffered entries plus the outstanding read must never exceed the buffer size.
   assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};

   // rst_n gates issue so mem_re drops as soon as reset is asserted.
   assign issue = rst_n && !bus.halt && !bus.redirect_valid && (credit_used < DEPTH_C);

   assign flush = bus.redirect_valid;
   assign push  = inflight_q && !bus.redirect_valid;
   assign pop   = !empty && bus.instr_ready;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (issue) begin
         pc_d          = pc_q + ADDR_W'(1);
         inflight_pc_d = pc_q;
      end
      if (bus.redirect_valid) pc_d = bus.redirect_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= ADDR_W'(RESET_PC);
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   instr_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({inflight_pc_q, bus.mem_rdata}),
      .pop   (pop),
      .flush (flush),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
   );

   assign bus.mem_addr    = pc_q;
   assign bus.mem_re      = issue;
   assign bus.instr_valid = !empty;
   assign bus.instr_pc    = head[WIDTH-1:DATA_W];
   assign bus.instr_data  = head[DATA_W-1:0];

   a_credit: assert property (@(posedge clk) disable iff (!rst_n)
      credit_used <= DEPTH_C);

   a_quiet_on_redirect: assert property (@(posedge clk) disable iff (!rst_n)
      bus.redirect_valid |-> !bus.mem_re);

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full));

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed phases push expected {pc, instr} entries and an
// independent monitor checks every decoder transfer against them in order.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   instr_fetch #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .RESET_PC (0),
      .DEPTH    (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 256-word memory: upper address bits are ignored.
   logic [DW-1:0] mem [256];
   always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[7:0]];

   fetch_entry_t exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic fetch_entry_t mk(input logic [AW-1:0] pc);
      fetch_entry_t e;
      e.pc    = pc;
      e.instr = 16'h1000 + {8'h00, pc[7:0]};
      return e;
   endfunction

   task automatic push_range(input int lo, input int hi);
      for (int p = lo; p <= hi; p++) exp_q.push_back(mk(AW'(p)));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      fetch_entry_t e;
      if (rst_n === 1'b1 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_extra: got pc 0x%0h, expected no transfer at %0t",
                     bus.instr_pc, $time);
         end else begin
            e = exp_q.pop_front();
            check("xfer_pc", 32'(bus.instr_pc), 32'(e.pc));
            check("xfer_data", 32'(bus.instr_data), 32'(e.instr));
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      rst_n              = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.halt           = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      step(2);
      check("rst_mem_addr", 32'(bus.mem_addr), 0);
      check("rst_mem_re", 32'(bus.mem_re), 0);
      check("rst_valid", 32'(bus.instr_valid), 0);
      check("rst_data", 32'(bus.instr_data), 0);
      check("rst_pc", 32'(bus.instr_pc), 0);

      // Streaming from reset, then a 10-cycle decoder stall.
      bus.instr_ready = 1'b1;
      push_range(0, 18);
      rst_n = 1'b1;                      // cycle 0
      #1;
      check("c0_issue", 32'(bus.mem_re), 1);
      step(1);
      check("c1_valid", 32'(bus.instr_valid), 0);
      step(1);
      check("c2_valid", 32'(bus.instr_valid), 1);
      check("c2_pc", 32'(bus.instr_pc), 0);
      step(10);                          // cycle 12
      bus.instr_ready = 1'b0;
      step(5);                           // cycle 17
      check("stall_mem_re", 32'(bus.mem_re), 0);
      check("stall_valid", 32'(bus.instr_valid), 1);
      check("stall_pc", 32'(bus.instr_pc), 10);
      check("stall_data", 32'(bus.instr_data), 'h100A);
      step(5);                           // cycle 22
      bus.instr_ready = 1'b1;

      // Redirect with entries buffered and one read in flight; pc 18 transfers in T.
      step(8);                           // cycle 30 = T
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 12'h040;
      #1;
      check("redir_mem_re", 32'(bus.mem_re), 0);
      push_range('h40, 'h46);
      step(1);                           // T+1
      bus.redirect_valid = 1'b0;
      #1;
      check("redir_issue", 32'(bus.mem_re), 1);
      check("redir_addr", 32'(bus.mem_addr), 'h40);
      step(1);                           // T+2
      check("redir_t2_valid", 32'(bus.instr_valid), 0);
      step(1);                           // T+3
      check("redir_t3_valid", 32'(bus.instr_valid), 1);
      check("redir_t3_pc", 32'(bus.instr_pc), 'h40);

      // PC wrap from 0xFFF to 0x000.
      step(6);                           // cycle 39
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 12'hFFF;
      exp_q.push_back(mk(12'hFFF));
      push_range(0, 13);
      step(1);                           // cycle 40
      bus.redirect_valid = 1'b0;
      #1;
      check("wrap_addr_fff", 32'(bus.mem_addr), 'hFFF);
      check("wrap_re_fff", 32'(bus.mem_re), 1);
      step(1);                           // cycle 41
      check("wrap_addr_000", 32'(bus.mem_addr), 0);
      check("wrap_re_000", 32'(bus.mem_re), 1);

      // Halt for 5 cycles; the in-flight pc 8 is still delivered.
      step(9);                           // cycle 50
      bus.halt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("halt_mem_re", 32'(bus.mem_re), 0);
         if (i == 1) begin
            check("halt_inflight_valid", 32'(bus.instr_valid), 1);
            check("halt_inflight_pc", 32'(bus.instr_pc), 8);
         end
         step(1);
      end
      bus.halt = 1'b0;                   // cycle 55
      #1;
      check("resume_re", 32'(bus.mem_re), 1);
      check("resume_addr", 32'(bus.mem_addr), 9);

      // Asynchronous reset mid-stream.
      step(6);                           // cycle 61
      check("pre_rst_valid", 32'(bus.instr_valid), 1);
      step(1);                           // cycle 62
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(bus.instr_valid), 0);
      check("async_rst_re", 32'(bus.mem_re), 0);
      check("async_rst_addr", 32'(bus.mem_addr), 0);
      check("drained_before_rst", 32'(exp_q.size()), 0);
      push_range(0, 5);
      step(2);
      rst_n = 1'b1;                      // cycle 0 again
      step(8);
      bus.instr_ready = 1'b0;
      step(4);
      check("restart_drained", 32'(exp_q.size()), 0);
      check("restart_valid", 32'(bus.instr_valid), 1);
      check("restart_head_pc", 32'(bus.instr_pc), 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
